dump_sequencer: RTL and testbench

Halt-time state dump controller for the debug path. After the processor halts, or on a host dump command, it sequences a fixed report over the 32-bit UART transmitter: PC, clock count, every register-bank entry, then a window of data memory. It drives the register-bank and data-memory debug read addresses, captures the returned words and handshakes each one into the UART TX. It sits between the debug command decoder and the UART TX and replaces ad-hoc send logic.

---
 rtl/dump_pkg.sv | 31 +++
 rtl/dump_sequencer_if.sv | 25 ++
 rtl/dump_addr_gen.sv | 66 ++++++
 rtl/dump_sequencer.sv | 102 ++++++++++
 tb/tb_dump_sequencer.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dump_pkg.sv
// Shared types for the halt-time dump path: FSM state codes, word-source select, word count.
// DUMP_DM_EN adds the data-memory window to the report.
package dump_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LOAD    = 3'd1;
    localparam state_t ST_CAPTURE = 3'd2;
    localparam state_t ST_START   = 3'd3;
    localparam state_t ST_WAIT    = 3'd4;
    localparam state_t ST_DONE    = 3'd5;

    typedef enum logic [1:0] {
        SRC_PC  = 2'd0,
        SRC_CLK = 2'd1,
        SRC_RB  = 2'd2,
        SRC_DM  = 2'd3
    } src_t;

`ifdef DUMP_DM_EN
    localparam bit DM_EN = 1'b1;
`else
    localparam bit DM_EN = 1'b0;
`endif

    function automatic int total_words(input int bank_size, input int dm_words, input bit dm_en);
        return 2 + bank_size + (dm_en ? dm_words : 0);
    endfunction

endpackage

// File: rtl/dump_sequencer_if.sv
// Debug-read and UART-TX signals between the dump sequencer (master) and the
// register bank / data memory / UART transmitter (slave).
interface dump_sequencer_if #(
    parameter int NBITS          = 32,
    parameter int RBITS          = 5,
    parameter int DM_ADDR_LENGTH = 32
);
    logic [RBITS-1:0]          RB_Addr;
    logic [NBITS-1:0]          RB_Data;
    logic [DM_ADDR_LENGTH-1:0] DM_Addr;
    logic [NBITS-1:0]          DM_Data;
    logic [NBITS-1:0]          tx_Data;
    logic                      tx_start;
    logic                      tx_done;

    modport master (
        output RB_Addr, DM_Addr, tx_Data, tx_start,
        input  RB_Data, DM_Data, tx_done
    );

    modport slave (
        input  RB_Addr, DM_Addr, tx_Data, tx_start,
        output RB_Data, DM_Data, tx_done
    );
endinterface

// File: rtl/dump_addr_gen.sv
// Word index counter for the dump report; maps the index to a source select and
// the debug read addresses. DUMP_DM_EN enables the data-memory address phase.
module dump_addr_gen
    import dump_pkg::*;
#(
    parameter int                        RBITS          = 5,
    parameter int                        BANK_SIZE      = 32,
    parameter int                        DM_ADDR_LENGTH = 32,
    parameter logic [DM_ADDR_LENGTH-1:0] DM_BASE        = '0,
    parameter int                        TOTAL          = 34,
    parameter int                        IW             = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      advance,
    output src_t                      src,
    output logic [RBITS-1:0]          rb_addr,
    output logic [DM_ADDR_LENGTH-1:0] dm_addr,
    output logic                      last
);
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;
    int            nxt_i;
    int            cur_i;

    always_comb begin
        idx_nxt = clear ? '0 : idx + IW'(1);
        nxt_i   = int'(idx_nxt);
        cur_i   = int'(idx);
        if (cur_i == 0)
            src = SRC_PC;
        else if (cur_i == 1)
            src = SRC_CLK;
        else if (cur_i <= BANK_SIZE + 1)
            src = SRC_RB;
        else
            src = SRC_DM;
    end

    assign last = (idx == IW'(TOTAL - 1));

    // Addresses are loaded together with the index so they are already valid in LOAD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx     <= '0;
            rb_addr <= '0;
        end else if (clear || advance) begin
            idx <= idx_nxt;
            if (nxt_i >= 2 && nxt_i <= BANK_SIZE + 1)
                rb_addr <= RBITS'(nxt_i - 2);
        end
    end

`ifdef DUMP_DM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            dm_addr <= DM_BASE;
        else if ((clear || advance) && nxt_i >= BANK_SIZE + 2)
            dm_addr <= DM_BASE + DM_ADDR_LENGTH'(4 * (nxt_i - BANK_SIZE - 2));
    end
`else
    assign dm_addr = DM_BASE;
`endif

endmodule

// File: rtl/dump_sequencer.sv
// Halt-time dump controller: sends PC, clock count, register bank and (with
// DUMP_DM_EN defined) a data-memory window over the UART TX, one word per handshake.
module dump_sequencer
    import dump_pkg::*;
#(
    parameter int                        NBITS          = 32,
    parameter int                        RBITS          = 5,
    parameter int                        BANK_SIZE      = 32,
    parameter int                        DM_ADDR_LENGTH = 32,
    parameter logic [DM_ADDR_LENGTH-1:0] DM_BASE        = '0,
    parameter int                        DM_DUMP_WORDS  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [NBITS-1:0]   current_pc,
    input  logic [NBITS-1:0]   clock_count,
    output logic               busy,
    output logic               done,
    dump_sequencer_if.master   bus
);
    localparam int TOTAL = total_words(BANK_SIZE, DM_DUMP_WORDS, DM_EN);
    localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    state_t           state;
    state_t           state_nxt;
    src_t             src;
    logic             last;
    logic             clear;
    logic             advance;
    logic [NBITS-1:0] word;

    assign clear   = (state == ST_IDLE) && start && !abort;
    assign advance = (state == ST_WAIT) && bus.tx_done && !last && !abort;

    dump_addr_gen #(
        .RBITS          (RBITS),
        .BANK_SIZE      (BANK_SIZE),
        .DM_ADDR_LENGTH (DM_ADDR_LENGTH),
        .DM_BASE        (DM_BASE),
        .TOTAL          (TOTAL),
        .IW             (IW)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .advance (advance),
        .src     (src),
        .rb_addr (bus.RB_Addr),
        .dm_addr (bus.DM_Addr),
        .last    (last)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_LOAD;
            ST_LOAD:    state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_START;
            ST_START:   state_nxt = ST_WAIT;
            ST_WAIT:    if (bus.tx_done) state_nxt = last ? ST_DONE : ST_LOAD;
            default:    state_nxt = ST_IDLE;
        endcase
        if (abort)
            state_nxt = ST_IDLE;
    end

    always_comb begin
        case (src)
            SRC_PC:  word = current_pc;
            SRC_CLK: word = clock_count;
            SRC_RB:  word = bus.RB_Data;
`ifdef DUMP_DM_EN
            SRC_DM:  word = bus.DM_Data;
`endif
            default: word = '0;
        endcase
    end

`ifndef DUMP_DM_EN
    logic unused_dm;
    assign unused_dm = ^bus.DM_Data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            bus.tx_Data <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CAPTURE && !abort)
                bus.tx_Data <= word;
        end
    end

    // Handshake outputs decode directly from the registered state.
    assign bus.tx_start = (state == ST_START);
    assign busy         = (state != ST_IDLE) && (state != ST_DONE);
    assign done         = (state == ST_DONE);

endmodule

// File: tb/tb_dump_sequencer.sv
// Scoreboard bench for dump_sequencer: memory and UART models, word-order and timing checks.
module tb_dump_sequencer;

    localparam int          BANK    = 32;
    localparam int          DMW     = 4;
    localparam logic [31:0] DM_BASE = 32'h0000_0200;
`ifdef DUMP_DM_EN
    localparam int          TOTAL   = 2 + BANK + DMW;
    localparam logic [31:0] LAST_DM = DM_BASE + 32'd12;
`else
    localparam int          TOTAL   = 2 + BANK;
    localparam logic [31:0] LAST_DM = DM_BASE;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] current_pc = '0;
    logic [31:0] clock_count = '0;
    logic        busy;
    logic        done;
    logic        uart_done = 1'b0;
    logic        stray_done = 1'b0;
    bit          uart_en = 1'b1;
    bit          uart_busy = 1'b0;
    int          uart_delay = 10;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          tx_count = 0;
    int          done_count = 0;
    int          dm_bad = 0;
    bit          in_frame = 1'b0;
    logic [31:0] held_word;
    logic [31:0] exp_word;
    logic [31:0] exp_q[$];
    int          tx_cyc_q[$];
    int          txd_cyc_q[$];
    int          done_cyc_q[$];

    dump_sequencer_if #(.NBITS(32), .RBITS(5), .DM_ADDR_LENGTH(32)) bus ();

    assign bus.tx_done = uart_done | stray_done;

    dump_sequencer #(
        .NBITS          (32),
        .RBITS          (5),
        .BANK_SIZE      (BANK),
        .DM_ADDR_LENGTH (32),
        .DM_BASE        (DM_BASE),
        .DM_DUMP_WORDS  (DMW)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .start       (start),
        .abort       (abort),
        .current_pc  (current_pc),
        .clock_count (clock_count),
        .busy        (busy),
        .done        (done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memories: data follows the address by one cycle.
    always @(posedge clk) begin
        bus.RB_Data <= 32'h100 + 32'(bus.RB_Addr);
        bus.DM_Data <= 32'hD000_0000 + ((bus.DM_Addr - DM_BASE) >> 2);
    end

    initial begin
        forever begin
            @(negedge clk);
            if (uart_en && bus.tx_start === 1'b1) begin
                uart_busy = 1'b1;
                repeat (uart_delay) @(posedge clk);
                #1 uart_done = 1'b1;
                txd_cyc_q.push_back(cyc);
                @(posedge clk);
                #1 uart_done = 1'b0;
                uart_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            in_frame = 1'b0;
        end else begin
            if (bus.tx_start === 1'b1) begin
                tx_count++;
                tx_cyc_q.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_word unexpected word got %h required none", bus.tx_Data);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (bus.tx_Data !== exp_word) begin
                        errors++;
                        $display("FAIL tx_word got %h required %h", bus.tx_Data, exp_word);
                    end
                end
                held_word = bus.tx_Data;
                in_frame  = 1'b1;
            end else if (in_frame && busy === 1'b1) begin
                checks++;
                if (bus.tx_Data !== held_word) begin
                    errors++;
                    $display("FAIL tx_stable got %h required %h", bus.tx_Data, held_word);
                end
            end
            if (bus.tx_done === 1'b1 || busy !== 1'b1)
                in_frame = 1'b0;
            if (done === 1'b1) begin
                done_count++;
                done_cyc_q.push_back(cyc);
            end
`ifndef DUMP_DM_EN
            if (bus.DM_Addr !== DM_BASE)
                dm_bad++;
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dump(input logic [31:0] pc, input logic [31:0] ck);
        exp_q.push_back(pc);
        exp_q.push_back(ck);
        for (int i = 0; i < BANK; i++)
            exp_q.push_back(32'h100 + 32'(i));
`ifdef DUMP_DM_EN
        for (int k = 0; k < DMW; k++)
            exp_q.push_back(32'hD000_0000 + 32'(k));
`endif
    endtask

    task automatic wait_tx(input int target, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (tx_count < target) begin
            tick();
            n++;
            if (n > 1000) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_done(input int target, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (done_count < target) begin
            tick();
            n++;
            if (n > 3000) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_uart_idle(output bit ok);
        int n = 0;
        ok = 1'b1;
        while (uart_busy) begin
            tick();
            n++;
            if (n > 100) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        #2 rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, done, bus.tx_start} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 000", {busy, done, bus.tx_start});
        end
        checks++;
        if (bus.tx_Data !== 32'h0 || bus.RB_Addr !== 5'd0 || bus.DM_Addr !== DM_BASE) begin
            errors++;
            $display("FAIL reset_data got tx=%h rb=%h dm=%h required 0/0/%h",
                     bus.tx_Data, bus.RB_Addr, bus.DM_Addr, DM_BASE);
        end
        rst_n = 1'b1;
        tick();
        current_pc  = 32'h1111_0000;
        clock_count = 32'h2222_0000;
        push_dump(current_pc, clock_count);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_tx(tx_count + 4, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_prep_timeout got %0d words required 4", tx_count);
        end
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, bus.tx_start} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async_ctrl got %b required 000", {busy, done, bus.tx_start});
        end
        checks++;
        if (bus.tx_Data !== 32'h0 || bus.RB_Addr !== 5'd0 || bus.DM_Addr !== DM_BASE) begin
            errors++;
            $display("FAIL reset_async_data got tx=%h rb=%h dm=%h required 0/0/%h",
                     bus.tx_Data, bus.RB_Addr, bus.DM_Addr, DM_BASE);
        end
        exp_q.delete();
        wait_uart_idle(ok);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || bus.tx_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b tx_start=%b required 0/0", busy, bus.tx_start);
        end
    endtask

    task automatic test_full_dump();
        bit ok;
        int tx0;
        int d0;
        int t0;
        int bad;
        tx0 = tx_count;
        d0  = done_count;
        tx_cyc_q.delete();
        txd_cyc_q.delete();
        done_cyc_q.delete();
        current_pc  = 32'h0040_1A2C;
        clock_count = 32'h0000_0001;
        push_dump(32'h0040_1A2C, 32'h0000_BEEF);
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        clock_count = 32'h0000_BEEF;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_latency got %b required 1", busy);
        end
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL full_timeout got %0d words required %0d", tx_count - tx0, TOTAL);
        end
        checks++;
        if (tx_count - tx0 != TOTAL) begin
            errors++;
            $display("FAIL full_count got %0d required %0d", tx_count - tx0, TOTAL);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_leftover got %0d required 0", exp_q.size());
        end
        checks++;
        if (tx_cyc_q.size() == 0 || tx_cyc_q[0] != t0 + 3) begin
            errors++;
            $display("FAIL start_latency got %0d required %0d",
                     (tx_cyc_q.size() == 0) ? -1 : tx_cyc_q[0] - t0, 3);
        end
        bad = 0;
        for (int i = 1; i < tx_cyc_q.size(); i++)
            if (i - 1 >= txd_cyc_q.size() || tx_cyc_q[i] != txd_cyc_q[i - 1] + 3)
                bad++;
        checks++;
        if (bad != 0 || txd_cyc_q.size() != TOTAL) begin
            errors++;
            $display("FAIL done_to_start_latency got %0d bad of %0d frames required 0 bad of %0d",
                     bad, txd_cyc_q.size(), TOTAL);
        end
        checks++;
        if (done_cyc_q.size() != 1 || txd_cyc_q.size() == 0 ||
            done_cyc_q[0] != txd_cyc_q[txd_cyc_q.size() - 1] + 1) begin
            errors++;
            $display("FAIL done_latency got %0d pulses required one pulse one cycle after last tx_done",
                     done_cyc_q.size());
        end
        checks++;
        if (bus.DM_Addr !== LAST_DM || bus.RB_Addr !== 5'd31) begin
            errors++;
            $display("FAIL final_addr got dm=%h rb=%0d required dm=%h rb=31",
                     bus.DM_Addr, bus.RB_Addr, LAST_DM);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_done got done=%b busy=%b required 0/0", done, busy);
        end
`ifndef DUMP_DM_EN
        checks++;
        if (dm_bad != 0) begin
            errors++;
            $display("FAIL dm_addr_tied got %0d moved cycles required 0", dm_bad);
        end
`endif
    endtask

    task automatic test_abort();
        bit ok;
        int tx0;
        int d0;
        tx0 = tx_count;
        d0  = done_count;
        current_pc  = 32'h0BAD_0000;
        clock_count = 32'h0000_0777;
        exp_q.push_back(32'h0BAD_0000);
        exp_q.push_back(32'h0000_0777);
        for (int i = 0; i < 4; i++)
            exp_q.push_back(32'h100 + 32'(i));
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_tx(tx0 + 6, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_prep_timeout got %0d words required 6", tx_count - tx0);
        end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({busy, done, bus.tx_start} !== 3'b000) begin
            errors++;
            $display("FAIL abort_idle got %b required 000", {busy, done, bus.tx_start});
        end
        wait_uart_idle(ok);
        repeat (5) tick();
        checks++;
        if (!ok || tx_count != tx0 + 6 || done_count != d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_late_done got words=%0d dones=%0d busy=%b required 6/0/0",
                     tx_count - tx0, done_count - d0, busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_leftover got %0d required 0", exp_q.size());
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle got busy=%b required 0", busy);
        end
        repeat (4) tick();
        checks++;
        if (tx_count != tx0 + 6) begin
            errors++;
            $display("FAIL start_abort_words got %0d required 6", tx_count - tx0);
        end
        current_pc = 32'h0BAD_1111;
        push_dump(32'h0BAD_1111, 32'h0000_0777);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok || tx_count != tx0 + 6 + TOTAL || exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_restart got %0d words left=%0d required %0d left=0",
                     tx_count - tx0 - 6, exp_q.size(), TOTAL);
        end
    endtask

    task automatic test_ignored_inputs();
        bit ok;
        int tx0;
        int d0;
        int n;
        tx0 = tx_count;
        d0  = done_count;
        current_pc  = 32'h5555_AAAA;
        clock_count = 32'h0000_0042;
        push_dump(current_pc, clock_count);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_tx(tx0 + 2, ok);
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (uart_done !== 1'b1 && n < 100);
        tick();
        tick();
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok || tx_count - tx0 != TOTAL) begin
            errors++;
            $display("FAIL ignored_count got %0d required %0d", tx_count - tx0, TOTAL);
        end
        checks++;
        if (done_count != d0 + 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ignored_done got dones=%0d left=%0d required 1/0",
                     done_count - d0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_abort();
        test_ignored_inputs();
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
